// File: rtl/dd_pkg.sv
// -----------------------------------------------------------------------------
// dd_pkg
//   Shared types and sizing helpers for the block-row scheduler (blk_sched).
//
//   state_e     : scheduler FSM states.
//   calc_nbv()  : number of block rows per frame, ceil(vp/kv).
//   calc_lvw()  : width of the line-in-row index, $clog2(kv).
//   calc_bvw()  : width of the block-row index, $clog2(vp/kv+1).
//   NBV/LVW/BVW : the same quantities for the default 1080-line, 10-line-row
//                 configuration. Parameterised instances size themselves
//                 through the helper functions instead.
// -----------------------------------------------------------------------------
package dd_pkg;

    typedef enum logic [1:0] {
        S_SYNC,    // waiting for the first vsync after reset
        S_VBLANK,  // vertical blanking, waiting for the first active pixel
        S_ACTIVE,  // counting active lines
        S_TAIL     // all active lines seen, waiting for the next vsync
    } state_e;

    localparam int DEF_VP = 1080;
    localparam int DEF_KV = 10;

    function automatic int calc_nbv(input int vp, input int kv);
        return (vp + kv - 1) / kv;
    endfunction

    // A one-line row would give a zero-width index; keep at least one bit.
    function automatic int calc_lvw(input int kv);
        return (kv > 1) ? $clog2(kv) : 1;
    endfunction

    function automatic int calc_bvw(input int vp, input int kv);
        return $clog2(vp / kv + 1);
    endfunction

    localparam int NBV = calc_nbv(DEF_VP, DEF_KV);
    localparam int LVW = calc_lvw(DEF_KV);
    localparam int BVW = calc_bvw(DEF_VP, DEF_KV);

endpackage

// File: rtl/blk_sched_if.sv
// -----------------------------------------------------------------------------
// blk_sched_if
//   Signals exchanged between the scheduler and its surroundings: the video
//   timing inputs, the dark-mode request, the block buffer handshake
//   (rx_i in, freeze_o out) and the pixel-mux invert select.
//   Names carry the direction as seen from the scheduler.
//
//   modport master : environment side (drives timing/request/rx, sees outputs)
//   modport slave  : scheduler side
//
//   vs_i      vsync, active-high
//   hs_i      hsync, active-high
//   de_i      data enable
//   en_i      dark-mode request, sampled once per frame
//   rx_i      current block decision from the buffer (1 = bright block)
//   freeze_o  single-cycle bank-swap pulse to the buffer
//   dark_o    invert select for the current pixel (one cycle latency)
// -----------------------------------------------------------------------------
interface blk_sched_if;

    logic vs_i;
    logic hs_i;
    logic de_i;
    logic en_i;
    logic rx_i;
    logic freeze_o;
    logic dark_o;

    modport master (
        output vs_i, hs_i, de_i, en_i, rx_i,
        input  freeze_o, dark_o
    );

    modport slave (
        input  vs_i, hs_i, de_i, en_i, rx_i,
        output freeze_o, dark_o
    );

endinterface

// File: rtl/edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
//   N-bit registered copy of d_i with one edge strobe per bit. Bit i strobes
//   on a falling edge when FALL[i] is set, otherwise on a rising edge. The
//   strobe is combinational from d_i and valid in the cycle the new level is
//   first seen.
//
//   clk_i   clock
//   rst_i   synchronous active-high reset (history cleared to 0)
//   d_i     level inputs
//   edge_o  per-bit edge strobes
// -----------------------------------------------------------------------------
module edge_det #(
    parameter int           N    = 1,
    parameter logic [N-1:0] FALL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] edge_o
);

    logic [N-1:0] prev_q;
    logic [N-1:0] prev_d;

    always_comb begin
        prev_d = d_i;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign edge_o = (d_i & ~prev_q & ~FALL) | (~d_i & prev_q & FALL);

endmodule

// File: rtl/blk_sched.sv
// -----------------------------------------------------------------------------
// blk_sched
//   Vertical sequencer for the per-block luminance buffer. Counts lines inside
//   each block row of KV lines, raises a bank-swap request when a row (or the
//   partial last row) completes, and issues it as a one-cycle freeze aligned
//   to the following hsync rising edge. Latches the dark-mode request once per
//   frame and gates the buffer's block decision into the pixel-path select.
//
//   Parameters
//     VP   active lines per frame
//     KV   lines per block row
//     FCW  width of the completed-frame counter
//
//   Ports
//     clk_i        pixel clock
//     rst_i        synchronous active-high reset
//     bus          timing / buffer / pixel-mux signals (blk_sched_if.slave)
//     lv_o         line index within the current block row
//     bv_o         block-row index, saturates at ceil(VP/KV)
//     frame_cnt_o  completed-frame count, wraps modulo 2^FCW
//     err_o        sticky overrun flag (short frame or extra active line)
// -----------------------------------------------------------------------------
module blk_sched
    import dd_pkg::*;
#(
    parameter int VP  = 1080,
    parameter int KV  = 10,
    parameter int FCW = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    blk_sched_if.slave                  bus,
    output logic [calc_lvw(KV)-1:0]     lv_o,
    output logic [calc_bvw(VP, KV)-1:0] bv_o,
    output logic [FCW-1:0]              frame_cnt_o,
    output logic                        err_o
);

    localparam int LVW = calc_lvw(KV);
    localparam int BVW = calc_bvw(VP, KV);
    localparam int NBV = calc_nbv(VP, KV);

    localparam logic [LVW-1:0] LV_LAST   = LVW'(KV - 1);
    localparam logic [BVW-1:0] BV_MAX    = BVW'(NBV);
    localparam logic [31:0]    LINE_LAST = 32'(VP - 1);

    // -------------------------------------------------------------------------
    // Edge strobes: bit 0 vsync rise, bit 1 hsync rise, bit 2 data-enable fall
    // (end of an active line).
    // -------------------------------------------------------------------------
    logic [2:0] edges;
    logic       vs_rise;
    logic       hs_rise;
    logic       line_end;

    edge_det #(
        .N    (3),
        .FALL (3'b100)
    ) u_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    ({bus.de_i, bus.hs_i, bus.vs_i}),
        .edge_o (edges)
    );

    assign vs_rise  = edges[0];
    assign hs_rise  = edges[1];
    assign line_end = edges[2];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e         state_q,     state_d;
    logic [LVW-1:0] lv_q,        lv_d;
    logic [BVW-1:0] bv_q,        bv_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           en_q,        en_d;
    logic           pend_q,      pend_d;
    logic           freeze_q,    freeze_d;
    logic           dark_q,      dark_d;
    logic           err_q,       err_d;

    logic           new_frame;
    logic [31:0]    line_idx;

    // Absolute index of the line currently being completed.
    assign line_idx = 32'(bv_q) * 32'(KV) + 32'(lv_q);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here is given a default first so no
        // path through the case statement can infer a latch.
        state_d     = state_q;
        lv_d        = lv_q;
        bv_d        = bv_q;
        frame_cnt_d = frame_cnt_q;
        en_d        = en_q;
        err_d       = err_q;
        new_frame   = 1'b0;

        // An hs_rise consumes the pending swap request. Requests raised below
        // in the same cycle are OR-ed back in and so wait for the next hs_rise,
        // keeping the bank swap on a line boundary.
        pend_d   = pend_q & ~hs_rise;
        freeze_d = pend_q & hs_rise & (state_q != S_SYNC);

        // First pixel of a frame is still seen in S_VBLANK and stays un-inverted.
        dark_d   = en_q & bus.de_i & ~bus.rx_i & (state_q == S_ACTIVE);

        unique case (state_q)
            S_SYNC: begin
                if (vs_rise) begin
                    new_frame = 1'b1;
                    state_d   = S_VBLANK;
                end
            end

            S_VBLANK: begin
                if (vs_rise) begin
                    new_frame = 1'b1;
                end
                if (bus.de_i) begin
                    state_d = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (vs_rise) begin
                    // Short frame: close it out as if the tail had been seen and
                    // flush a partially filled row (including one that a
                    // coincident line end would have completed).
                    err_d       = 1'b1;
                    frame_cnt_d = frame_cnt_q + FCW'(1);
                    new_frame   = 1'b1;
                    state_d     = S_VBLANK;
                    if ((lv_q != '0) || line_end) begin
                        pend_d = 1'b1;
                    end
                end else if (line_end) begin
                    if (lv_q == LV_LAST) begin
                        lv_d   = '0;
                        bv_d   = (bv_q == BV_MAX) ? bv_q : bv_q + BVW'(1);
                        pend_d = 1'b1;
                    end else begin
                        lv_d = lv_q + LVW'(1);
                    end
                    // Last active line: a full row already requested its swap
                    // above, a partial row is flushed here.
                    if (line_idx == LINE_LAST) begin
                        state_d = S_TAIL;
                        pend_d  = 1'b1;
                    end
                end
            end

            S_TAIL: begin
                if (vs_rise) begin
                    frame_cnt_d = frame_cnt_q + FCW'(1);
                    new_frame   = 1'b1;
                    state_d     = S_VBLANK;
                end else if (line_end) begin
                    // More active lines than the frame geometry allows.
                    err_d = 1'b1;
                end
            end
        endcase

        // Frame start: the dark-mode request is sampled only here, so mid-frame
        // changes wait for the next vsync.
        if (new_frame) begin
            en_d = bus.en_i;
            lv_d = '0;
            bv_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_SYNC;
            lv_q        <= '0;
            bv_q        <= '0;
            frame_cnt_q <= '0;
            en_q        <= 1'b0;
            pend_q      <= 1'b0;
            freeze_q    <= 1'b0;
            dark_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lv_q        <= lv_d;
            bv_q        <= bv_d;
            frame_cnt_q <= frame_cnt_d;
            en_q        <= en_d;
            pend_q      <= pend_d;
            freeze_q    <= freeze_d;
            dark_q      <= dark_d;
            err_q       <= err_d;
        end
    end

    assign bus.freeze_o = freeze_q;
    assign bus.dark_o   = dark_q;
    assign lv_o         = lv_q;
    assign bv_o         = bv_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_blk_sched.sv
// -----------------------------------------------------------------------------
// tb_blk_sched
//   Directed bench for blk_sched. Three instances share one stimulus stream:
//     u_a : VP=30, KV=10, FCW=16   (full rows, dark mode, short frame, reset)
//     u_b : VP=25, KV=10, FCW=16   (partial last row, extra-line overrun)
//     u_c : VP=30, KV=10, FCW=2    (frame counter wrap)
//   Each scenario resets all instances and checks only its own instance.
//   Line shape (14 clocks): hs high p=0..1, de high p=4..11.
//   Freeze pulses are logged as line*100+p of the stimulus cycle whose
//   hs_rise produced them; blank lines use tags 100..102 (vsync line first)
//   and 200 (tail line after the active lines).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_blk_sched;
    import dd_pkg::*;

    localparam int LINE_LEN = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vs  = 1'b0;
    logic hs  = 1'b0;
    logic de  = 1'b0;
    logic en  = 1'b0;
    logic rx  = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int a_frz[$];
    int b_frz[$];
    int a_dark = 0;

    blk_sched_if if_a ();
    blk_sched_if if_b ();
    blk_sched_if if_c ();

    assign if_a.vs_i = vs;  assign if_a.hs_i = hs;  assign if_a.de_i = de;
    assign if_a.en_i = en;  assign if_a.rx_i = rx;
    assign if_b.vs_i = vs;  assign if_b.hs_i = hs;  assign if_b.de_i = de;
    assign if_b.en_i = en;  assign if_b.rx_i = rx;
    assign if_c.vs_i = vs;  assign if_c.hs_i = hs;  assign if_c.de_i = de;
    assign if_c.en_i = en;  assign if_c.rx_i = rx;

    logic [3:0]  lv_a, lv_b, lv_c;
    logic [1:0]  bv_a, bv_b, bv_c;
    logic [15:0] fc_a, fc_b;
    logic [1:0]  fc_c;
    logic        err_a, err_b, err_c;

    blk_sched #(.VP(30), .KV(10), .FCW(16)) u_a (
        .clk_i(clk), .rst_i(rst), .bus(if_a),
        .lv_o(lv_a), .bv_o(bv_a), .frame_cnt_o(fc_a), .err_o(err_a)
    );

    blk_sched #(.VP(25), .KV(10), .FCW(16)) u_b (
        .clk_i(clk), .rst_i(rst), .bus(if_b),
        .lv_o(lv_b), .bv_o(bv_b), .frame_cnt_o(fc_b), .err_o(err_b)
    );

    blk_sched #(.VP(30), .KV(10), .FCW(2)) u_c (
        .clk_i(clk), .rst_i(rst), .bus(if_c),
        .lv_o(lv_c), .bv_o(bv_c), .frame_cnt_o(fc_c), .err_o(err_c)
    );

    // ------------------------------------------------------------------
    // Stimulus primitives
    // ------------------------------------------------------------------
    // Drive one cycle, let the DUT clock it, then log what it produced.
    task automatic tick(input logic v, input logic h, input logic d, input int tag);
        vs = v; hs = h; de = d;
        @(posedge clk); #1;
        if (if_a.freeze_o === 1'b1) a_frz.push_back(tag);
        if (if_b.freeze_o === 1'b1) b_frz.push_back(tag);
        if (if_a.dark_o === 1'b1) a_dark++;
    endtask

    task automatic blank_line(input int ln, input logic v);
        for (int p = 0; p < LINE_LEN; p++) tick(v, p < 2, 1'b0, ln * 100 + p);
    endtask

    task automatic active_lines(input int first, input int count);
        for (int l = first; l < first + count; l++)
            for (int p = 0; p < LINE_LEN; p++)
                tick(1'b0, p < 2, (p >= 4) && (p < 12), l * 100 + p);
    endtask

    task automatic vsync_part();
        blank_line(100, 1'b1);
        blank_line(101, 1'b0);
        blank_line(102, 1'b0);
    endtask

    task automatic tail_part();
        blank_line(200, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        a_frz.delete();
        b_frz.delete();
        a_dark = 0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++; if (if_a.freeze_o !== 1'b0) begin errors++; $display("FAIL reset_freeze got %b want 0", if_a.freeze_o); end
        checks++; if (if_a.dark_o !== 1'b0) begin errors++; $display("FAIL reset_dark got %b want 0", if_a.dark_o); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_a); end
        checks++; if (lv_a !== 4'd0) begin errors++; $display("FAIL reset_lv got %0d want 0", lv_a); end
        checks++; if (bv_a !== 2'd0) begin errors++; $display("FAIL reset_bv got %0d want 0", bv_a); end
        checks++; if (fc_a !== 16'd0) begin errors++; $display("FAIL reset_fc got %0d want 0", fc_a); end
        checks++; if (u_a.state_q !== S_SYNC) begin errors++; $display("FAIL reset_state got %0d want %0d", u_a.state_q, S_SYNC); end
        checks++; if (fc_c !== 2'd0) begin errors++; $display("FAIL reset_fc_c got %0d want 0", fc_c); end
    endtask

    task automatic test_full_frame();
        int exp_tag[3] = '{1000, 2000, 20000};
        int got;
        do_reset();
        en = 1'b0; rx = 1'b0;
        vsync_part();
        active_lines(0, 30);
        tail_part();
        checks++; if (a_frz.size() != 3) begin errors++; $display("FAIL full_freeze_count got %0d want 3", a_frz.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < a_frz.size()) ? a_frz[i] : -1;
            checks++; if (got != exp_tag[i]) begin errors++; $display("FAIL full_freeze_tag%0d got %0d want %0d", i, got, exp_tag[i]); end
        end
        checks++; if (bv_a !== 2'd3) begin errors++; $display("FAIL full_bv got %0d want 3", bv_a); end
        checks++; if (lv_a !== 4'd0) begin errors++; $display("FAIL full_lv got %0d want 0", lv_a); end
        checks++; if (fc_a !== 16'd0) begin errors++; $display("FAIL full_fc_before_vs got %0d want 0", fc_a); end
        vsync_part();
        checks++; if (fc_a !== 16'd1) begin errors++; $display("FAIL full_fc_after_vs got %0d want 1", fc_a); end
        checks++; if (bv_a !== 2'd0) begin errors++; $display("FAIL full_bv_cleared got %0d want 0", bv_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL full_err got %b want 0", err_a); end
        checks++; if (a_frz.size() != 3) begin errors++; $display("FAIL full_no_extra_freeze got %0d want 3", a_frz.size()); end
    endtask

    task automatic test_partial_row();
        int exp_tag[3] = '{1000, 2000, 20000};
        int got;
        do_reset();
        vsync_part();
        active_lines(0, 25);
        tail_part();
        checks++; if (b_frz.size() != 3) begin errors++; $display("FAIL partial_freeze_count got %0d want 3", b_frz.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < b_frz.size()) ? b_frz[i] : -1;
            checks++; if (got != exp_tag[i]) begin errors++; $display("FAIL partial_freeze_tag%0d got %0d want %0d", i, got, exp_tag[i]); end
        end
        checks++; if (lv_b !== 4'd5) begin errors++; $display("FAIL partial_lv got %0d want 5", lv_b); end
        checks++; if (bv_b !== 2'd2) begin errors++; $display("FAIL partial_bv got %0d want 2", bv_b); end
        vsync_part();
        active_lines(0, 25);
        tail_part();
        checks++; if (b_frz.size() != 6) begin errors++; $display("FAIL partial_two_frames got %0d want 6", b_frz.size()); end
        checks++; if (fc_b !== 16'd1) begin errors++; $display("FAIL partial_fc got %0d want 1", fc_b); end
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL partial_err got %b want 0", err_b); end
        // One active line beyond the last one is an overrun.
        active_lines(25, 1);
        checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL extra_line_err got %b want 1", err_b); end
    endtask

    task automatic test_dark_mode();
        logic d, r, exp_now, exp_prev;
        do_reset();
        en = 1'b0; rx = 1'b0;
        vsync_part();
        active_lines(0, 15);
        en = 1'b1;
        active_lines(15, 15);
        tail_part();
        checks++; if (a_dark != 0) begin errors++; $display("FAIL dark_midframe_en got %0d dark cycles want 0", a_dark); end
        vsync_part();
        active_lines(0, 1);
        // Dropping the request mid-frame must not stop inversion this frame.
        en = 1'b0;
        exp_prev = 1'b0;
        for (int p = 0; p < LINE_LEN; p++) begin
            d = (p >= 4) && (p < 12);
            r = (p == 7) || (p == 9);
            vs = 1'b0; hs = (p < 2); de = d; rx = r;
            #1;
            checks++; if (if_a.dark_o !== exp_prev) begin errors++; $display("FAIL dark_latency p%0d got %b want %b", p, if_a.dark_o, exp_prev); end
            @(posedge clk); #1;
            exp_now = d & ~r;
            checks++; if (if_a.dark_o !== exp_now) begin errors++; $display("FAIL dark_value p%0d got %b want %b", p, if_a.dark_o, exp_now); end
            exp_prev = exp_now;
        end
        rx = 1'b0;
    endtask

    task automatic test_short_frame();
        int exp_tag[2] = '{1000, 10100};
        int got;
        do_reset();
        en = 1'b0;
        vsync_part();
        active_lines(0, 15);
        checks++; if (lv_a !== 4'd5) begin errors++; $display("FAIL short_lv got %0d want 5", lv_a); end
        checks++; if (bv_a !== 2'd1) begin errors++; $display("FAIL short_bv got %0d want 1", bv_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL short_err_before got %b want 0", err_a); end
        vsync_part();
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", err_a); end
        checks++; if (a_frz.size() != 2) begin errors++; $display("FAIL short_freeze_count got %0d want 2", a_frz.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < a_frz.size()) ? a_frz[i] : -1;
            checks++; if (got != exp_tag[i]) begin errors++; $display("FAIL short_freeze_tag%0d got %0d want %0d", i, got, exp_tag[i]); end
        end
        checks++; if (lv_a !== 4'd0) begin errors++; $display("FAIL short_lv_cleared got %0d want 0", lv_a); end
        checks++; if (bv_a !== 2'd0) begin errors++; $display("FAIL short_bv_cleared got %0d want 0", bv_a); end
        checks++; if (fc_a !== 16'd1) begin errors++; $display("FAIL short_fc got %0d want 1", fc_a); end
        active_lines(0, 30);
        tail_part();
        vsync_part();
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL short_err_sticky got %b want 1", err_a); end
        checks++; if (fc_a !== 16'd2) begin errors++; $display("FAIL short_fc_next got %0d want 2", fc_a); end
    endtask

    task automatic test_reset_pending();
        do_reset();
        vsync_part();
        active_lines(0, 10);
        // Row 0 has completed; its swap waits for the hs of line 10.
        checks++; if (bv_a !== 2'd1) begin errors++; $display("FAIL rstpend_bv_before got %0d want 1", bv_a); end
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 9999);
        rst = 1'b0;
        checks++; if (if_a.freeze_o !== 1'b0) begin errors++; $display("FAIL rstpend_freeze got %b want 0", if_a.freeze_o); end
        checks++; if (bv_a !== 2'd0) begin errors++; $display("FAIL rstpend_bv got %0d want 0", bv_a); end
        checks++; if (lv_a !== 4'd0) begin errors++; $display("FAIL rstpend_lv got %0d want 0", lv_a); end
        checks++; if (fc_a !== 16'd0) begin errors++; $display("FAIL rstpend_fc got %0d want 0", fc_a); end
        checks++; if (u_a.state_q !== S_SYNC) begin errors++; $display("FAIL rstpend_state got %0d want %0d", u_a.state_q, S_SYNC); end
        active_lines(10, 3);
        checks++; if (a_frz.size() != 0) begin errors++; $display("FAIL rstpend_no_freeze got %0d want 0", a_frz.size()); end
        checks++; if (lv_a !== 4'd0) begin errors++; $display("FAIL rstpend_sync_ignores got %0d want 0", lv_a); end
        checks++; if (u_a.state_q !== S_SYNC) begin errors++; $display("FAIL rstpend_still_sync got %0d want %0d", u_a.state_q, S_SYNC); end
    endtask

    task automatic test_fcnt_wrap();
        logic [1:0] exp_fc[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            vsync_part();
            checks++; if (fc_c !== exp_fc[i]) begin errors++; $display("FAIL wrap_fc%0d got %0d want %0d", i, fc_c, exp_fc[i]); end
            if (i < 4) begin
                active_lines(0, 30);
                tail_part();
            end
        end
        checks++; if (err_c !== 1'b0) begin errors++; $display("FAIL wrap_err got %b want 0", err_c); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_partial_row();
        test_dark_mode();
        test_short_frame();
        test_reset_pending();
        test_fcnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
